// File: rtl/mod_seq_ctrl.sv
// mod_seq_ctrl: bus-mapped sequencer computing X % (X - Y) with a one-bit-per-clock restoring divider
module mod_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int OUT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             E,
  input  logic             W,
  input  logic             R,
  input  logic [1:0]       ADDR,
  input  logic [WIDTH-1:0] D,
  output logic [OUT_W-1:0] OUT,
  output logic             BUSY,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, DIFF, ITER, FIN} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] x, y, div, xs, rem, result, diff, rem_nx;
  logic [WIDTH:0] t;
  logic [CW-1:0] cnt;
  logic [OUT_W-1:0] rdata;
  logic dz, wr, rd, start, clr;
  assign wr = E & W;
  assign rd = E & R;
  assign BUSY = state != IDLE;
  assign start = wr && ADDR == 2'd3 && D[0] && !BUSY;
  assign clr = wr && ADDR == 2'd3 && (D[0] || D[1]) && (start || D[1]);
  assign diff = x - y;
  assign t = {rem, xs[WIDTH-1]};
  assign rem_nx = (t >= {1'b0, div}) ? WIDTH'(t - {1'b0, div}) : t[WIDTH-1:0];
  // read mux sees pre-edge register values, so read-during-write returns the old value
  always_comb
    rdata = ADDR == 2'd0 ? OUT_W'(x) :
            ADDR == 2'd1 ? OUT_W'(y) :
            ADDR == 2'd2 ? OUT_W'(result) : OUT_W'({dz, DONE, BUSY});
  // state register
  always_ff @(posedge CLK)
    if (RST) state <= IDLE;
    else state <= state_nx;
  // next state: a zero divisor skips the iterations
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = start ? DIFF : IDLE;
      DIFF: state_nx = diff == '0 ? FIN : ITER;
      ITER: state_nx = cnt == CW'(WIDTH - 1) ? FIN : ITER;
      FIN:  state_nx = IDLE;
    endcase
  end
  // bus registers, shift-subtract datapath and sticky flags; completion wins over a same-cycle clear
  always_ff @(posedge CLK)
    if (RST) begin
      x <= '0;
      y <= '0;
      div <= '0;
      xs <= '0;
      rem <= '0;
      result <= '0;
      cnt <= '0;
      OUT <= '0;
      DONE <= 1'b0;
      dz <= 1'b0;
    end else begin
      if (wr && !BUSY && ADDR == 2'd0) x <= D;
      if (wr && !BUSY && ADDR == 2'd1) y <= D;
      if (rd) OUT <= rdata;
      if (clr) begin
        DONE <= 1'b0;
        dz <= 1'b0;
      end
      if (state == DIFF) begin
        div <= diff;
        xs <= x;
        rem <= '0;
        cnt <= '0;
        if (diff == '0) dz <= 1'b1;
      end
      if (state == ITER) begin
        xs <= xs << 1;
        rem <= rem_nx;
        cnt <= cnt + 1'b1;
      end
      if (state == FIN) begin
        result <= dz ? '0 : rem;
        DONE <= 1'b1;
      end
    end
endmodule

// File: doc/mod_seq_ctrl.md
Name: mod_seq_ctrl

Overview:
Memory-mapped sequencer for an iterative unsigned modulo engine. It computes RESULT = X % (X - Y), with the difference taken modulo 2^WIDTH. Software loads X and Y through the W/ADDR/D bus, triggers a start through a control register, then polls the status register or the DONE port. The restoring shift-subtract datapath runs one bit per clock, so there is no wide combinational divider.

Parameters:
WIDTH, 16, operand/result width; the bit counter is clog2(WIDTH)+1 bits wide.
OUT_W, 32, read-data width; read values are zero-extended to OUT_W.

Ports:
CLK  input  1  rising-edge clock
RST  input  1  synchronous active-high reset
E  input  1  chip enable; W and R are ignored when E=0
W  input  1  write strobe, sampled at posedge CLK
R  input  1  read strobe, sampled at posedge CLK
ADDR  input  2  register select: 0=X, 1=Y, 2=RESULT (read-only), 3=CTRL/STATUS
D  input  WIDTH  write data
OUT  output  OUT_W  registered read data
BUSY  output  1  engine running
DONE  output  1  result valid, sticky

Behaviour:
Reset (RST=1 at a posedge) clears state, and takes priority over any W, R or start in the same cycle:
- State goes to IDLE; X, Y, DIV, REM, RESULT and the counter go to 0.
- OUT=0, BUSY=0, DONE=0, DZ=0.
- Reset mid-computation aborts the operation with no result.

Bus:
- Write (E&W):
  - ADDR 0/1 loads X/Y, only when BUSY=0; otherwise the write is ignored.
  - ADDR 2 writes are ignored.
  - ADDR 3: D[0]=1 is START; D[1]=1 clears DONE and DZ. If both are set, START wins: DONE/DZ are cleared and the engine starts.
- Read (E&R):
  - OUT <= zero-extended register value at the same edge.
  - ADDR 3 returns {0.., DZ, DONE, BUSY} in bits [2:0].
  - OUT holds its value when there is no read.
  - A read and a write to the same address in one cycle returns the pre-write value.

State machine (IDLE, DIFF, ITER, FIN):
- IDLE:
  - START at edge k → DIFF. BUSY=1 and DONE=DZ=0 are visible after edge k.
  - START while BUSY=1 is ignored.
- DIFF, edge k+1:
  - DIV <= X - Y (WIDTH bits, wraps); XS <= X snapshot; REM <= 0; counter <= 0.
  - If X - Y == 0: go to FIN with DZ=1 and RESULT=0.
  - Otherwise go to ITER.
- ITER, edges k+2 .. k+WIDTH+1 (one iteration per edge):
  - T = {REM, XS[MSB]} (WIDTH+1 bits); XS <<= 1.
  - REM <= (T >= DIV) ? T - DIV : T.
  - After WIDTH iterations, go to FIN.
- FIN, one cycle:
  - RESULT <= REM (or 0 if DZ); BUSY=0; DONE=1; go to IDLE.
  - Total latency: RESULT and DONE are visible after edge k+WIDTH+2, i.e. 18 cycles for WIDTH=16. The DZ path takes 3 cycles.
- DONE/DZ stay set until the next START, a clear write, or reset.
- RESULT holds its value until the next FIN; a START does not clear RESULT.

Arithmetic:
- All arithmetic is unsigned.
- REM needs WIDTH+1 bits internally to avoid overflow when DIV > 2^(WIDTH-1).
- If DIV > X, the result is X.

Test Plan:
1. X=8, Y=4, START → DIV=4; after 18 cycles DONE=1, read ADDR2 → OUT=0x00000000, DZ=0.
2. X=100, Y=1 → DIV=99, RESULT=1. X=65535, Y=32000 → DIV=33535, RESULT=32000 (exercises the WIDTH+1 remainder).
3. X=5, Y=5 → DZ=1 and DONE=1 three cycles after START; STATUS reads 0x6; RESULT=0.
4. X=3, Y=10 → DIV wraps to 65529, RESULT=3. While BUSY, write X=7 and a second START: both are ignored, X still reads 3, and latency stays 18.
5. Assert RST at ITER cycle 5 → next cycle BUSY=0, DONE=0, OUT=0, all registers read 0. A following X=100, Y=1 run completes correctly.
6. E=0 with W/R active → no register change, OUT holds. A D=0x2 write to ADDR3 after completion → STATUS reads 0x0, RESULT unchanged.
